// File: rtl/my_down_counter_pkg.sv
// rtl/my_down_counter_pkg.sv - shared width constant and FSM state type for my_down_counter_16
//
// Contents:
//   WIDTH   : counter and load width (16 is the only supported value)
//   state_t : controller states IDLE, RUN, PAUSED, DONE
package my_down_counter_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/my_decrementer_16.sv
// rtl/my_decrementer_16.sv - combinational 16-bit decrementer, out = x - 1 mod 2^16
//
// Ports:
//   x   : input  [15:0] operand
//   out : output [15:0] x - 1, wrapping 0x0000 -> 0xFFFF
module my_decrementer_16 (
  input  logic [my_down_counter_pkg::WIDTH-1:0] x,
  output logic [my_down_counter_pkg::WIDTH-1:0] out
);

  import my_down_counter_pkg::*;

  // Plain modular subtraction; the caller is responsible for never feeding
  // zero when a wrap would be illegal.
  assign out = x - WIDTH'(1);

endmodule

// File: rtl/my_down_counter_16.sv
// rtl/my_down_counter_16.sv - loadable 16-bit down counter with pause, abort and auto-reload
//
// Ports:
//   clk         : input         rising-edge clock
//   rst_n       : input         asynchronous active-low reset
//   load_value  : input  [15:0] start count, sampled when a start is accepted
//   start       : input         one-cycle load-and-run request (IDLE/DONE only)
//   pause       : input         level, holds the count while high
//   abort       : input         one-cycle return to IDLE, highest priority
//   auto_reload : input         level, reload at terminal count instead of finishing
//   count       : output [15:0] registered counter value
//   busy        : output        high in RUN or PAUSED
//   done        : output        high in DONE
//   tc          : output        registered one-cycle terminal-count pulse
module my_down_counter_16 #(
  parameter int WIDTH = my_down_counter_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  import my_down_counter_pkg::*;

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] count_dec;
  logic             tc_q;
  logic             busy_q;
  logic             done_q;

  my_decrementer_16 u_dec (
    .x   (count_q),
    .out (count_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // tc is a single-cycle pulse: cleared unless a terminal count fires now.
      tc_q <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        count_q <= '0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              if (load_value != '0) begin
                state    <= RUN;
                count_q  <= load_value;
                reload_q <= load_value;
                busy_q   <= 1'b1;
                done_q   <= 1'b0;
              end else begin
                // A zero load is an immediate terminal count; it must not
                // enter RUN, where decrementing would wrap to all-ones.
                state    <= DONE;
                count_q  <= '0;
                reload_q <= '0;
                tc_q     <= 1'b1;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
              end
            end
          end

          RUN: begin
            // start is deliberately ignored while a run is in progress.
            if (pause) begin
              state <= PAUSED;
            end else if (count_q == WIDTH'(1)) begin
              tc_q <= 1'b1;
              if (auto_reload) begin
                count_q <= reload_q;
              end else begin
                state   <= DONE;
                count_q <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else if (count_q == '0) begin
              // Unreachable in normal operation; finish cleanly rather than wrap.
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              count_q <= count_dec;
            end
          end

          PAUSED: begin
            // Resume without decrementing on the release edge.
            if (!pause) begin
              state <= RUN;
            end
          end

          default: begin
            state   <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_my_down_counter_16.sv
// tb/tb_my_down_counter_16.sv - self-checking bench for my_down_counter_16 and my_decrementer_16
module tb_my_down_counter_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] load_value;
  logic        start;
  logic        pause;
  logic        abort;
  logic        auto_reload;
  logic [15:0] count;
  logic        busy;
  logic        done;
  logic        tc;

  logic [15:0] dec_x;
  logic [15:0] dec_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  my_down_counter_16 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_value  (load_value),
    .start       (start),
    .pause       (pause),
    .abort       (abort),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .tc          (tc)
  );

  my_decrementer_16 u_dec_standalone (
    .x   (dec_x),
    .out (dec_out)
  );

  typedef struct {
    logic        start;
    logic        pause;
    logic        abort;
    logic        ar;
    logic [15:0] lv;
    logic [15:0] exp_count;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [15:0] c, input logic b,
                         input logic d, input logic t);
    chk16({name, ".count"}, count, c);
    chk1({name, ".busy"}, busy, b);
    chk1({name, ".done"}, done, d);
    chk1({name, ".tc"}, tc, t);
  endtask

  task automatic drive(input logic s, input logic p, input logic a, input logic ar,
                       input logic [15:0] lv);
    start       = s;
    pause       = p;
    abort       = a;
    auto_reload = ar;
    load_value  = lv;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic s, input logic p, input logic a, input logic ar,
                     input logic [15:0] lv, input logic [15:0] c, input logic b,
                     input logic d, input logic t);
    vec_t v;
    v.start = s; v.pause = p; v.abort = a; v.ar = ar; v.lv = lv;
    v.exp_count = c; v.exp_busy = b; v.exp_done = d; v.exp_tc = t;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] dec_in  [5];
    logic [15:0] dec_exp [5];

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 16'h0000);
    dec_x = 16'h0000;

    // Reset state
    repeat (2) @(negedge clk);
    chk_out("reset", 16'h0000, 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk_out("idle_after_reset", 16'h0000, 0, 0, 0);

    // start pause abort ar  load      count     busy done tc
    add(1, 0, 0, 0, 16'd3,   16'd3, 1, 0, 0);
    add(0, 0, 0, 0, 16'd0,   16'd2, 1, 0, 0);
    add(0, 0, 0, 0, 16'd0,   16'd1, 1, 0, 0);
    add(0, 0, 0, 0, 16'd0,   16'd0, 0, 1, 1);
    add(0, 0, 0, 0, 16'd0,   16'd0, 0, 1, 0);
    add(1, 0, 0, 1, 16'd2,   16'd2, 1, 0, 0);
    add(0, 0, 0, 1, 16'd0,   16'd1, 1, 0, 0);
    add(0, 0, 0, 1, 16'd0,   16'd2, 1, 0, 1);
    add(0, 0, 0, 1, 16'd0,   16'd1, 1, 0, 0);
    add(0, 0, 0, 1, 16'd0,   16'd2, 1, 0, 1);
    add(1, 0, 0, 1, 16'd9,   16'd1, 1, 0, 0);
    add(0, 0, 0, 0, 16'd0,   16'd0, 0, 1, 1);
    add(1, 0, 0, 0, 16'd0,   16'd0, 0, 1, 1);
    add(0, 0, 0, 0, 16'd0,   16'd0, 0, 1, 0);
    add(1, 0, 0, 1, 16'd0,   16'd0, 0, 1, 1);
    add(1, 0, 1, 0, 16'd5,   16'd0, 0, 0, 0);
    add(0, 0, 0, 0, 16'd0,   16'd0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].pause, vecs[i].abort, vecs[i].ar, vecs[i].lv);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_busy,
              vecs[i].exp_done, vecs[i].exp_tc);
    end

    // Pause for three cycles at count 5, release without a decrement.
    drive(1, 0, 0, 0, 16'd8);
    step(); chk_out("pause.load", 16'd8, 1, 0, 0);
    drive(0, 0, 0, 0, 16'd0);
    step(); chk_out("pause.c7", 16'd7, 1, 0, 0);
    step(); chk_out("pause.c6", 16'd6, 1, 0, 0);
    step(); chk_out("pause.c5", 16'd5, 1, 0, 0);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_out($sformatf("pause.hold%0d", i), 16'd5, 1, 0, 0);
    end
    pause = 1'b0;
    step(); chk_out("pause.release", 16'd5, 1, 0, 0);
    step(); chk_out("pause.c4", 16'd4, 1, 0, 0);
    step(); chk_out("pause.c3", 16'd3, 1, 0, 0);
    step(); chk_out("pause.c2", 16'd2, 1, 0, 0);
    step(); chk_out("pause.c1", 16'd1, 1, 0, 0);
    step(); chk_out("pause.c0", 16'd0, 0, 1, 1);

    // Pause exactly at count 1 must not fire tc.
    drive(1, 0, 0, 0, 16'd2);
    step(); chk_out("p1.load", 16'd2, 1, 0, 0);
    drive(0, 0, 0, 0, 16'd0);
    step(); chk_out("p1.c1", 16'd1, 1, 0, 0);
    pause = 1'b1;
    step(); chk_out("p1.hold", 16'd1, 1, 0, 0);
    pause = 1'b0;
    step(); chk_out("p1.release", 16'd1, 1, 0, 0);
    step(); chk_out("p1.c0", 16'd0, 0, 1, 1);

    // Abort mid-run at 0x0F0A.
    drive(1, 0, 0, 0, 16'h0F0F);
    step(); chk_out("abort.load", 16'h0F0F, 1, 0, 0);
    drive(0, 0, 0, 0, 16'd0);
    repeat (5) step();
    chk_out("abort.pre", 16'h0F0A, 1, 0, 0);
    abort = 1'b1;
    step(); chk_out("abort.hit", 16'h0000, 0, 0, 0);
    abort = 1'b0;
    step(); chk_out("abort.after", 16'h0000, 0, 0, 0);

    // Asynchronous reset between edges mid-run.
    drive(1, 0, 0, 0, 16'd10);
    step(); chk_out("rst.load", 16'd10, 1, 0, 0);
    drive(0, 0, 0, 0, 16'd0);
    step(); chk_out("rst.c9", 16'd9, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_out("rst.async", 16'h0000, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); chk_out("rst.idle", 16'h0000, 0, 0, 0);

    // Load 1 with auto_reload: tc on consecutive cycles.
    drive(1, 0, 0, 1, 16'd1);
    step(); chk_out("r1.load", 16'd1, 1, 0, 0);
    drive(0, 0, 0, 1, 16'd0);
    step(); chk_out("r1.reload", 16'd1, 1, 0, 1);
    auto_reload = 1'b0;
    step(); chk_out("r1.finish", 16'd0, 0, 1, 1);
    drive(0, 0, 0, 0, 16'd0);

    // Standalone decrementer.
    dec_in[0] = 16'h0001; dec_exp[0] = 16'h0000;
    dec_in[1] = 16'h0004; dec_exp[1] = 16'h0003;
    dec_in[2] = 16'h0F10; dec_exp[2] = 16'h0F0F;
    dec_in[3] = 16'h0000; dec_exp[3] = 16'hFFFF;
    dec_in[4] = 16'h0F00; dec_exp[4] = 16'h0EFF;
    for (int i = 0; i < 5; i++) begin
      dec_x = dec_in[i];
      #1;
      chk16($sformatf("dec[%h]", dec_in[i]), dec_out, dec_exp[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
